// File: rtl/apb3_pkg.sv
// ----------------------------------------------------------------------------
// apb3_pkg
// Shared definitions for the APB3 initiator: FSM state encoding, the data
// width and the default parameter values. The helper function sizes the
// ACCESS wait counter.
// ----------------------------------------------------------------------------
package apb3_pkg;

   localparam int DATA_WIDTH         = 32;
   localparam int DEFAULT_ADDR_WIDTH = 16;
   localparam int DEFAULT_TIMEOUT    = 255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apbState_t;

   // Counter width able to hold maxVal. A disabled timeout (0) still needs a
   // one-bit counter so that the vector declaration stays legal.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/apb3_timeout_cnt.sv
// ----------------------------------------------------------------------------
// apb3_timeout_cnt
// Counts ACCESS cycles during which the completer holds PREADY low and flags
// when the count has reached TIMEOUT. The count saturates at TIMEOUT rather
// than wrapping. TIMEOUT = 0 disables the timeout: expired never asserts.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   clear    in   restart the count at zero (asserted the cycle before ACCESS)
//   enable   in   count this cycle (ACCESS with PREADY low)
//   expired  out  count equals TIMEOUT and the timeout is enabled
// ----------------------------------------------------------------------------
module apb3_timeout_cnt
   import apb3_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW    = cntWidth(TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam logic          TIMEOUT_ON = (TIMEOUT > 0);

   logic [CW-1:0] waitCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waitCnt <= '0;
      end else if (clear) begin
         waitCnt <= '0;
      end else if (enable && (waitCnt != LIMIT)) begin
         waitCnt <= waitCnt + CW'(1);
      end
   end

   assign expired = TIMEOUT_ON && (waitCnt == LIMIT);

endmodule

// File: rtl/apb3_master.sv
// ----------------------------------------------------------------------------
// apb3_master
// Single-outstanding APB3 initiator. A command accepted on the cmd handshake
// becomes one SETUP + ACCESS transfer; the result is presented on the rsp
// handshake and held until taken. A stalled ACCESS phase is aborted after
// TIMEOUT wait cycles (0 disables the abort).
//
// Ports
//   io_systemClk / io_systemReset   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata    command fields, latched on accept
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_error/rsp_timeout response fields
//   busy                            transaction in progress
//   PADDR..PSLVERROR                APB3 initiator port
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | APB setup phase, PSEL high, PENABLE low
// ACCESS | APB access phase, waiting for PREADY or the timeout
// RESP   | response held on rsp_* until rsp_ready
// ----------------------------------------------------------------------------
module apb3_master
   import apb3_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                  io_systemClk,
   input  logic                  io_systemReset,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  rsp_timeout,

   output logic                  busy,

   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERROR
);

   apbState_t state;
   apbState_t nextState;

   logic cmdAccept;
   logic accessDone;
   logic accessAbort;
   logic waitExpired;

   always_ff @(posedge io_systemClk or posedge io_systemReset) begin
      if (io_systemReset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState   = state;
      cmdAccept   = 1'b0;
      accessDone  = 1'b0;
      accessAbort = 1'b0;
      cmd_ready   = 1'b0;
      PSEL        = 1'b0;
      PENABLE     = 1'b0;
      rsp_valid   = 1'b0;
      busy        = 1'b1;

      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               cmdAccept = 1'b1;
               nextState = SETUP;
            end
         end
         SETUP: begin
            PSEL      = 1'b1;
            nextState = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            // A completer that answers on the cycle the timeout would fire
            // still gets its response through.
            if (PREADY) begin
               accessDone = 1'b1;
               nextState  = RESP;
            end else if (waitExpired) begin
               accessAbort = 1'b1;
               nextState   = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // The APB request fields are loaded at accept time so they are already
   // valid in SETUP, and they keep their value through IDLE afterwards.
   always_ff @(posedge io_systemClk or posedge io_systemReset) begin
      if (io_systemReset) begin
         PADDR       <= '0;
         PWRITE      <= 1'b0;
         PWDATA      <= '0;
         rsp_rdata   <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         if (cmdAccept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
         end
         if (accessDone) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_error   <= PSLVERROR;
            rsp_timeout <= 1'b0;
         end else if (accessAbort) begin
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
         end
      end
   end

   // Cleared during SETUP so the count starts at zero on the first ACCESS cycle.
   apb3_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeoutCnt (
      .clk     (io_systemClk),
      .rst     (io_systemReset),
      .clear   (state == SETUP),
      .enable  ((state == ACCESS) && !PREADY),
      .expired (waitExpired)
   );

endmodule

// File: tb/tb_apb3_master.sv
module tb_apb3_master;

   localparam int AW  = 16;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [31:0]   cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic          rsp_error;
   logic          rsp_timeout;
   logic          busy;
   logic [AW-1:0] PADDR;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA    = '0;
   logic          PREADY    = 1'b0;
   logic          PSLVERROR = 1'b0;

   int nTests = 0;
   int nFail  = 0;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      int            waitCycles;   // ACCESS cycles with PREADY low before it rises
      logic [31:0]   prdata;
      logic          slverr;
      logic [31:0]   expRdata;
      logic          expErr;
      logic          expTo;
      int            expLat;       // cycles from accept to first rsp_valid
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } rsp_t;

   rsp_t sb[$];
   vec_t vecs[8];

   apb3_master #(
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TMO)
   ) dut (
      .io_systemClk   (clk),
      .io_systemReset (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_write      (cmd_write),
      .cmd_addr       (cmd_addr),
      .cmd_wdata      (cmd_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_error      (rsp_error),
      .rsp_timeout    (rsp_timeout),
      .busy           (busy),
      .PADDR          (PADDR),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PWDATA         (PWDATA),
      .PRDATA         (PRDATA),
      .PREADY         (PREADY),
      .PSLVERROR      (PSLVERROR)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic popCheck(input string tag);
      rsp_t e;
      nTests++;
      if (sb.size() == 0) begin
         nFail++;
         $display("FAIL %s scoreboard: rsp_valid with no expected response queued", tag);
      end else begin
         nTests--;
         e = sb.pop_front();
         chk($sformatf("%s rsp_rdata", tag), rsp_rdata, e.rdata);
         chk($sformatf("%s rsp_error", tag), rsp_error, e.err);
         chk($sformatf("%s rsp_timeout", tag), rsp_timeout, e.to);
      end
   endtask

   // One transaction: issue the command, play the completer, check the response.
   task automatic runTxn(input vec_t v, input string tag);
      int   acc  = 0;
      bit   done = 0;
      rsp_t e;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("%s cmd_ready idle", tag), cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      e.rdata = v.expRdata;
      e.err   = v.expErr;
      e.to    = v.expTo;
      sb.push_back(e);
      @(posedge clk);
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge clk);
         // Junk on the command port must be ignored while busy.
         cmd_valid = 1'b0;
         cmd_addr  = ~v.addr;
         cmd_write = ~v.write;
         cmd_wdata = ~v.wdata;
         if (k == 1) begin
            chk($sformatf("%s setup PSEL", tag), PSEL, 1);
            chk($sformatf("%s setup PENABLE", tag), PENABLE, 0);
            chk($sformatf("%s setup PADDR", tag), PADDR, v.addr);
            chk($sformatf("%s setup PWRITE", tag), PWRITE, v.write);
            if (v.write) chk($sformatf("%s setup PWDATA", tag), PWDATA, v.wdata);
         end
         if (PSEL && PENABLE) begin
            chk($sformatf("%s access PADDR", tag), PADDR, v.addr);
            chk($sformatf("%s access PWRITE", tag), PWRITE, v.write);
            PREADY    = (acc == v.waitCycles);
            PRDATA    = PREADY ? v.prdata : (32'hBAD0_0000 + acc);
            PSLVERROR = PREADY ? v.slverr : 1'b1;
            acc++;
         end else begin
            PREADY    = 1'b0;
            PSLVERROR = 1'b1;
            PRDATA    = 32'hFFFF_0000;
         end
         if (rsp_valid) begin
            chk($sformatf("%s latency", tag), k, v.expLat);
            chk($sformatf("%s access cycles", tag), acc, v.expLat - 2);
            chk($sformatf("%s resp PSEL", tag), PSEL, 0);
            chk($sformatf("%s resp busy", tag), busy, 1);
            popCheck(tag);
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            chk($sformatf("%s rsp_valid drop", tag), rsp_valid, 0);
            chk($sformatf("%s back to idle", tag), cmd_ready, 1);
            chk($sformatf("%s PADDR held", tag), PADDR, v.addr);
            done = 1;
         end
      end
      PSLVERROR = 1'b0;
      if (!done) begin
         nTests++;
         nFail++;
         $display("FAIL %s response: no rsp_valid within 40 cycles", tag);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v2;
      //          wr    addr      wdata          wait prdata         err   expRdata       eErr  eTo   lat
      vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF,  0,  32'h5555_5555, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 3};
      vecs[1] = '{1'b0, 16'h0004, 32'h0,         3,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 6};
      vecs[2] = '{1'b0, 16'h0008, 32'h0,         0,  32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F, 1'b1, 1'b0, 3};
      vecs[3] = '{1'b0, 16'h00FF, 32'h0,         99, 32'h7777_7777, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 7};
      vecs[4] = '{1'b0, 16'h0100, 32'h0,         4,  32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 7};
      vecs[5] = '{1'b1, 16'hFFFF, 32'h0123_4567, 2,  32'h9999_9999, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 5};
      vecs[6] = '{1'b1, 16'h1234, 32'h8000_0001, 99, 32'h6666_6666, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 7};
      vecs[7] = '{1'b0, 16'h0002, 32'h0,         1,  32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4};

      // Reset values while reset is asserted.
      #2;
      chk("reset PSEL", PSEL, 0);
      chk("reset PENABLE", PENABLE, 0);
      chk("reset PADDR", PADDR, 0);
      chk("reset PWRITE", PWRITE, 0);
      chk("reset PWDATA", PWDATA, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset rsp_error", rsp_error, 0);
      chk("reset rsp_timeout", rsp_timeout, 0);
      chk("reset busy", busy, 0);
      chk("reset cmd_ready", cmd_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         runTxn(vecs[i], $sformatf("vec%0d", i));
      end

      // Response back-pressure with the next command already waiting.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 16'h0020;
      cmd_wdata = 32'h0;
      sb.push_back('{32'h0BAD_CAFE, 1'b0, 1'b0});
      @(negedge clk);
      cmd_write = 1'b1;
      cmd_addr  = 16'h0030;
      cmd_wdata = 32'h1111_2222;
      chk("bp setup PADDR", PADDR, 16'h0020);
      @(negedge clk);
      chk("bp access PENABLE", PENABLE, 1);
      chk("bp access PADDR", PADDR, 16'h0020);
      chk("bp access PWRITE", PWRITE, 0);
      PREADY = 1'b1;
      PRDATA = 32'h0BAD_CAFE;
      @(negedge clk);
      PREADY = 1'b0;
      PRDATA = 32'h0;
      chk("bp rsp_valid", rsp_valid, 1);
      popCheck("bp");
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp hold%0d rsp_valid", i), rsp_valid, 1);
         chk($sformatf("bp hold%0d rsp_rdata", i), rsp_rdata, 32'h0BAD_CAFE);
         chk($sformatf("bp hold%0d rsp_error", i), rsp_error, 0);
         chk($sformatf("bp hold%0d cmd_ready", i), cmd_ready, 0);
         chk($sformatf("bp hold%0d PSEL", i), PSEL, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      v2 = '{1'b1, 16'h0030, 32'h1111_2222, 0, 32'h4444_4444, 1'b0, 32'h0, 1'b0, 1'b0, 3};
      runTxn(v2, "bp second");

      // Reset pulse in the middle of ACCESS.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 16'h0ABC;
      cmd_wdata = 32'h5A5A_5A5A;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rstmid in access", PENABLE, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid PSEL", PSEL, 0);
      chk("rstmid PENABLE", PENABLE, 0);
      chk("rstmid PADDR", PADDR, 0);
      chk("rstmid PWDATA", PWDATA, 0);
      chk("rstmid busy", busy, 0);
      chk("rstmid rsp_valid", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rstmid after%0d cmd_ready", i), cmd_ready, 1);
         chk($sformatf("rstmid after%0d rsp_valid", i), rsp_valid, 0);
      end

      chk("scoreboard drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
